// File: rtl/chacha_core_pkg.sv
// ChaCha core shared definitions.
// Holds the word geometry of the 4x4 ChaCha state, the four "expand 32-byte k"
// sigma constants that seed words 0-3, the block/word types and the FSM state
// enum used by the core.
package chacha_core_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 16;

    localparam logic [WORD_W-1:0] SIGMA0 = 32'h61707865;
    localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320646e;
    localparam logic [WORD_W-1:0] SIGMA2 = 32'h79622d32;
    localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b206574;

    typedef logic [WORD_W-1:0] word_t;

    // Word i of the state lives in bits [32*i +: 32].
    typedef logic [NUM_WORDS-1:0][WORD_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_e;

endpackage

// File: rtl/chacha_core_round.sv
// One ChaCha round: four quarter rounds applied in parallel to the four columns
// (a=w[j], b=w[4+j], c=w[8+j], d=w[12+j]) of the state.
// Diagonal rounds are obtained by the caller rotating rows b, c, d before and
// after this block.
// Ports:
//   state_i : block_t input state
//   state_o : block_t state after four column quarter rounds
module chacha_core_round
    import chacha_core_pkg::*;
(
    input  block_t state_i,
    output block_t state_o
);

    // Standard ChaCha quarter round; returns {a, b, c, d}.
    function automatic logic [4*WORD_W-1:0] quarter_round(
        input word_t a_in,
        input word_t b_in,
        input word_t c_in,
        input word_t d_in
    );
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        a = a_in;
        b = b_in;
        c = c_in;
        d = d_in;
        a = a + b;  d = d ^ a;  d = {d[15:0], d[31:16]};
        c = c + d;  b = b ^ c;  b = {b[19:0], b[31:20]};
        a = a + b;  d = d ^ a;  d = {d[23:0], d[31:24]};
        c = c + d;  b = b ^ c;  b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    for (genvar j = 0; j < 4; j++) begin : g_column
        assign {state_o[j], state_o[4+j], state_o[8+j], state_o[12+j]} =
            quarter_round(state_i[j], state_i[4+j], state_i[8+j], state_i[12+j]);
    end

endmodule

// File: rtl/chacha_core.sv
// ChaCha block function core, one round per clock.
// A request (key, nonce, counter) is accepted in IDLE, NUM_ROUNDS rounds run in
// ROUND, FINAL adds the initial state back in, and DONE holds the keystream
// block until the consumer takes it.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (in_ready only in IDLE)
//   key, nonce, counter : block inputs, sampled on the accept cycle only
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   keystream           : finished 512-bit block, word i at [32*i +: 32]
module chacha_core
    import chacha_core_pkg::*;
#(
    parameter int NUM_ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] keystream
);

    localparam int RCW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
    localparam logic [RCW-1:0] LAST_ROUND = RCW'(NUM_ROUNDS - 1);

    state_e         state_q, state_d;
    logic [RCW-1:0] round_q, round_d;
    block_t         work_q, work_d;
    block_t         init_q, init_d;
    block_t         ks_q, ks_d;

    block_t round_in;
    block_t round_out;
    block_t round_res;
    logic   diagonal;

    // Odd round indices are diagonal rounds.
    assign diagonal = round_q[0];

    // Rotating rows b, c, d left by 1, 2, 3 words lines the diagonals up as
    // columns, so the same column-round hardware serves both round types.
    always_comb begin
        round_in = work_q;
        if (diagonal) begin
            for (int j = 0; j < 4; j++) begin
                round_in[4+j]  = work_q[4  + ((j + 1) % 4)];
                round_in[8+j]  = work_q[8  + ((j + 2) % 4)];
                round_in[12+j] = work_q[12 + ((j + 3) % 4)];
            end
        end
    end

    chacha_core_round u_round (
        .state_i (round_in),
        .state_o (round_out)
    );

    // Undo the row rotation so the working state keeps its natural word order.
    always_comb begin
        round_res = round_out;
        if (diagonal) begin
            for (int j = 0; j < 4; j++) begin
                round_res[4  + ((j + 1) % 4)] = round_out[4+j];
                round_res[8  + ((j + 2) % 4)] = round_out[8+j];
                round_res[12 + ((j + 3) % 4)] = round_out[12+j];
            end
        end
    end

    // Next-state logic for the FSM and the datapath registers.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        work_d  = work_q;
        init_d  = init_q;
        ks_d    = ks_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    init_d  = {nonce, counter, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
                    work_d  = {nonce, counter, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
                    round_d = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                work_d = round_res;
                if (round_q == LAST_ROUND) begin
                    round_d = '0;
                    state_d = FINAL;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            FINAL: begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    ks_d[i] = work_q[i] + init_q[i];
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            work_q  <= '0;
            init_q  <= '0;
            ks_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            work_q  <= work_d;
            init_q  <= init_d;
            ks_q    <= ks_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign keystream = ks_q;

endmodule

// File: doc/chacha_core.md
CHACHA_CORE -- requirements
Module: chacha_core

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 20, giving the total rounds per block (even, >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request carries a valid key/nonce/counter.
REQ-005 SHALL have port in_ready  output  1  core accepts a request this cycle.
REQ-006 SHALL have port key  input  256  key; key[32*i+:32] is state word 4+i.
REQ-007 SHALL have port nonce  input  96  nonce; nonce[32*i+:32] is state word 13+i.
REQ-008 SHALL have port counter  input  32  block counter; becomes state word 12.
REQ-009 SHALL have port out_valid  output  1  keystream holds a finished block.
REQ-010 SHALL have port out_ready  input  1  consumer takes the block this cycle.
REQ-011 SHALL have port keystream  output  512  finished block; keystream[32*i+:32] is word i.

Function
REQ-012 SHALL implement the FSM states IDLE, ROUND, FINAL, DONE.
REQ-013 SHALL drive in_ready high only in IDLE; accept when in_valid && in_ready, moving to ROUND.
REQ-014 On accept, SHALL load the working and initial registers: words 0-3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574; words 4-11 key; word 12 counter; words 13-15 nonce.
REQ-015 SHALL apply one round per clock in ROUND, using a round counter of $clog2(NUM_ROUNDS) bits that starts at 0.
REQ-016 Even round index SHALL be a column round: rows a(w0-3), b(w4-7), c(w8-11), d(w12-15) go unrotated into the round sub-module.
REQ-017 Odd round index SHALL be a diagonal round: b, c, d are rotated left by 1, 2, 3 words before the round sub-module and rotated back after it, giving QR(0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
REQ-018 After round NUM_ROUNDS-1, SHALL enter FINAL; the round counter wraps to 0.
REQ-019 In FINAL, SHALL register keystream word i = working word i + initial word i (mod 2^32, carry discarded), then enter DONE.
REQ-020 SHALL hold out_valid high in DONE only.
REQ-021 SHALL keep keystream stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready, SHALL return to IDLE and raise in_ready the next cycle; requests are not overlapped.
REQ-023 Latency SHALL be NUM_ROUNDS+2 cycles from the accept edge to out_valid high (22 for the default).
REQ-024 SHALL ignore in_valid outside IDLE; key, nonce and counter need only be valid on the accept cycle.

Reset
REQ-025 rst SHALL asynchronously force IDLE, round counter 0, in_ready 1 after release, out_valid 0, keystream 0, and working/initial registers 0.
REQ-026 rst asserted mid-block (ROUND, FINAL or DONE) SHALL abort the block with no output produced.

Structure
REQ-027 A shared package SHALL hold the four sigma constants, the word width (32), the state word count (16) and the FSM state enum.
REQ-028 SHALL instantiate exactly one existing round sub-module (four parallel quarter rounds) and reuse it for column and diagonal rounds via word-rotation muxes; no other sub-module.

Verification
REQ-029 RFC 8439 2.3.2 vector, key bytes 00..1f (word4 = 0x03020100), nonce words 0x09000000/0x4a000000/0x00000000, counter 1 -> keystream words 0-3 = e4e7f110 15593bd1 1fdd0f50 c47120a3, and word 15 = 4e3c50a2, at cycle 22.
REQ-030 Hold out_ready low for 10 cycles after out_valid -> out_valid stays 1, keystream unchanged, in_ready stays 0.
REQ-031 Back-to-back requests (in_valid held, counter 1 then 2) -> second accept one cycle after the first output handshake, with a distinct keystream.
REQ-032 Assert rst at round 7 of a block -> out_valid 0, in_ready 1 after release, and the next request yields the correct vector.
REQ-033 Pulse in_valid during ROUND with different inputs -> ignored; the output matches the originally accepted request.
REQ-034 All-zero key, nonce and counter -> keystream word 0 = 0xade0b876 (RFC 7539 A.1 vector 1).
